// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE bit positions, mux codes and attribute strings
// for the DSP48A1-style slice.
package dsp48a1_pkg;

  localparam int AB_W = 18;
  localparam int M_W  = 36;
  localparam int P_W  = 48;
  localparam int OP_W = 8;

  localparam int OP_X_LSB      = 0;
  localparam int OP_Z_LSB      = 2;
  localparam int OP_PREADD_SEL = 4;
  localparam int OP_CARRY      = 5;
  localparam int OP_PREADD_SUB = 6;
  localparam int OP_POST_SUB   = 7;

  localparam logic [1:0] X_ZERO   = 2'd0;
  localparam logic [1:0] X_M      = 2'd1;
  localparam logic [1:0] X_P      = 2'd2;
  localparam logic [1:0] X_CONCAT = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam string CARRYINSEL_OPMODE5 = "OPMODE5";
  localparam string CARRYINSEL_CARRYIN = "CARRYIN";
  localparam string B_INPUT_DIRECT     = "DIRECT";
  localparam string B_INPUT_CASCADE    = "CASCADE";

endpackage

// File: rtl/dsp48a1_slice_if.sv
// Operand, control and result bundle of the DSP48A1-style slice.
interface dsp48a1_slice_if;
  import dsp48a1_pkg::*;

  logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [AB_W-1:0] A, B, BCIN, D;
  logic [P_W-1:0]  C, PCIN;
  logic            CARRYIN;
  logic [OP_W-1:0] OPMODE;
  logic [AB_W-1:0] BCOUT;
  logic [M_W-1:0]  M;
  logic [P_W-1:0]  P, PCOUT;
  logic            CARRYOUT, CARRYOUTF;

  modport master (
    output RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
    output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
    output A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
    input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
    input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
    input  A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
    output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
  );

endinterface

// File: rtl/dsp48a1_pipe_reg.sv
// One pipeline stage: an enabled flop with async clear when RSEL=1,
// a plain wire when RSEL=0 (clock, reset and enable then have no effect).
module dsp48a1_pipe_reg #(
  parameter int WIDTH = 18,
  parameter int RSEL  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (RSEL == 1) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (ce) begin
          q <= d;
        end
      end
    end else begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: pre-adder, 18x18 multiplier, 48-bit post-adder with carry.
// Define DSP48A1_SIGNED_MULT_EN for a signed multiplier with sign-extended M on the X mux.
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input logic            CLK,
  dsp48a1_slice_if.slave bus
);

  localparam bit CIN_FROM_OP5   = (CARRYINSEL == CARRYINSEL_OPMODE5);
  localparam bit CIN_FROM_PIN   = (CARRYINSEL == CARRYINSEL_CARRYIN);
  localparam bit B_FROM_DIRECT  = (B_INPUT == B_INPUT_DIRECT);
  localparam bit B_FROM_CASCADE = (B_INPUT == B_INPUT_CASCADE);

  logic [OP_W-1:0] opmode_r;
  logic [AB_W-1:0] d_r, b_sel, b0, a0, a1, b1, b1_in, pre_sum;
  logic [P_W-1:0]  c_r, x_mux, z_mux, p_r, m_ext;
  logic [M_W-1:0]  m_prod, m_r;
  logic            cin_sel, cin_r, co_r;
  logic [P_W:0]    post_sum;

  always_comb begin
    b_sel = '0;
    if (B_FROM_DIRECT) begin
      b_sel = bus.B;
    end else if (B_FROM_CASCADE) begin
      b_sel = bus.BCIN;
    end
  end

  dsp48a1_pipe_reg #(.WIDTH(OP_W), .RSEL(OPMODEREG)) u_opmode_reg (
    .clk(CLK), .rst(bus.RSTOPMODE), .ce(bus.CEOPMODE), .d(bus.OPMODE), .q(opmode_r));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .RSEL(DREG)) u_d_reg (
    .clk(CLK), .rst(bus.RSTD), .ce(bus.CED), .d(bus.D), .q(d_r));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .RSEL(B0REG)) u_b0_reg (
    .clk(CLK), .rst(bus.RSTB), .ce(bus.CEB), .d(b_sel), .q(b0));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .RSEL(A0REG)) u_a0_reg (
    .clk(CLK), .rst(bus.RSTA), .ce(bus.CEA), .d(bus.A), .q(a0));
  dsp48a1_pipe_reg #(.WIDTH(P_W), .RSEL(CREG)) u_c_reg (
    .clk(CLK), .rst(bus.RSTC), .ce(bus.CEC), .d(bus.C), .q(c_r));

  assign pre_sum = opmode_r[OP_PREADD_SUB] ? (d_r - b0) : (d_r + b0);
  assign b1_in   = opmode_r[OP_PREADD_SEL] ? pre_sum : b0;

  dsp48a1_pipe_reg #(.WIDTH(AB_W), .RSEL(B1REG)) u_b1_reg (
    .clk(CLK), .rst(bus.RSTB), .ce(bus.CEB), .d(b1_in), .q(b1));
  dsp48a1_pipe_reg #(.WIDTH(AB_W), .RSEL(A1REG)) u_a1_reg (
    .clk(CLK), .rst(bus.RSTA), .ce(bus.CEA), .d(a0), .q(a1));

`ifdef DSP48A1_SIGNED_MULT_EN
  logic signed [M_W-1:0] a1_s, b1_s;
  assign a1_s   = {{(M_W-AB_W){a1[AB_W-1]}}, a1};
  assign b1_s   = {{(M_W-AB_W){b1[AB_W-1]}}, b1};
  assign m_prod = a1_s * b1_s;
  assign m_ext  = {{(P_W-M_W){m_r[M_W-1]}}, m_r};
`else
  assign m_prod = {{(M_W-AB_W){1'b0}}, a1} * {{(M_W-AB_W){1'b0}}, b1};
  assign m_ext  = {{(P_W-M_W){1'b0}}, m_r};
`endif

  dsp48a1_pipe_reg #(.WIDTH(M_W), .RSEL(MREG)) u_m_reg (
    .clk(CLK), .rst(bus.RSTM), .ce(bus.CEM), .d(m_prod), .q(m_r));

  assign cin_sel = CIN_FROM_OP5 ? opmode_r[OP_CARRY] :
                   (CIN_FROM_PIN ? bus.CARRYIN : 1'b0);

  dsp48a1_pipe_reg #(.WIDTH(1), .RSEL(CARRYINREG)) u_cin_reg (
    .clk(CLK), .rst(bus.RSTCARRYIN), .ce(bus.CECARRYIN), .d(cin_sel), .q(cin_r));

  always_comb begin
    x_mux = '0;
    case (opmode_r[OP_X_LSB +: 2])
      X_ZERO:   x_mux = '0;
      X_M:      x_mux = m_ext;
      X_P:      x_mux = p_r;
      X_CONCAT: x_mux = {d_r[11:0], a1, b1};
      default:  x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opmode_r[OP_Z_LSB +: 2])
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = bus.PCIN;
      Z_P:     z_mux = p_r;
      Z_C:     z_mux = c_r;
      default: z_mux = '0;
    endcase
  end

  // Bit 48 is the carry when adding and the borrow of the 49-bit difference when subtracting.
  always_comb begin
    if (opmode_r[OP_POST_SUB]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_r});
    end else begin
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_r};
    end
  end

  dsp48a1_pipe_reg #(.WIDTH(P_W), .RSEL(PREG)) u_p_reg (
    .clk(CLK), .rst(bus.RSTP), .ce(bus.CEP), .d(post_sum[P_W-1:0]), .q(p_r));

  // The carry-out flop shares the carry-in stage's reset and enable, as on the hardware slice.
  dsp48a1_pipe_reg #(.WIDTH(1), .RSEL(CARRYOUTREG)) u_co_reg (
    .clk(CLK), .rst(bus.RSTCARRYIN), .ce(bus.CECARRYIN), .d(post_sum[P_W]), .q(co_r));

  assign bus.BCOUT     = b1;
  assign bus.M         = m_r;
  assign bus.P         = p_r;
  assign bus.PCOUT     = p_r;
  assign bus.CARRYOUT  = co_r;
  assign bus.CARRYOUTF = co_r;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Bench for dsp48a1_slice: default-parameter slice against a reference model,
// plus a cascade/bypass configuration with hand-computed expectations.
module tb_dsp48a1_slice;

  logic clk;
  int   checks;
  int   errors;
  logic model_on;

  dsp48a1_slice_if dif ();
  dsp48a1_slice_if cif ();

  dsp48a1_slice dut_default (.CLK(clk), .bus(dif));

  dsp48a1_slice #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .CREG(0), .DREG(0),
    .MREG(0), .PREG(1), .CARRYINREG(0), .CARRYOUTREG(0), .OPMODEREG(0),
    .CARRYINSEL("OPMODE5"), .B_INPUT("CASCADE")
  ) dut_cascade (.CLK(clk), .bus(cif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] a, input logic [17:0] b, input logic [17:0] bcin,
                               input logic [17:0] d, input logic [47:0] c, input logic [47:0] pcin,
                               input logic carryin, input logic [7:0] opmode);
    dif.A = a; dif.B = b; dif.BCIN = bcin; dif.D = d; dif.C = c; dif.PCIN = pcin;
    dif.CARRYIN = carryin; dif.OPMODE = opmode;
    cif.A = a; cif.B = b; cif.BCIN = bcin; cif.D = d; cif.C = c; cif.PCIN = pcin;
    cif.CARRYIN = carryin; cif.OPMODE = opmode;
  endtask

  // Mask bits: 0 A, 1 B, 2 C, 3 D, 4 M, 5 P, 6 CARRYIN, 7 OPMODE
  task automatic set_controls(input logic [7:0] rst, input logic [7:0] ce);
    {dif.RSTOPMODE, dif.RSTCARRYIN, dif.RSTP, dif.RSTM, dif.RSTD, dif.RSTC, dif.RSTB, dif.RSTA} = rst;
    {dif.CEOPMODE, dif.CECARRYIN, dif.CEP, dif.CEM, dif.CED, dif.CEC, dif.CEB, dif.CEA} = ce;
    {cif.RSTOPMODE, cif.RSTCARRYIN, cif.RSTP, cif.RSTM, cif.RSTD, cif.RSTC, cif.RSTB, cif.RSTA} = rst;
    {cif.CEOPMODE, cif.CECARRYIN, cif.CEP, cif.CEM, cif.CED, cif.CEC, cif.CEB, cif.CEA} = ce;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [35:0] mult(input logic [17:0] a, input logic [17:0] b);
`ifdef DSP48A1_SIGNED_MULT_EN
    logic signed [35:0] sa, sb;
    sa = {{18{a[17]}}, a};
    sb = {{18{b[17]}}, b};
    return sa * sb;
`else
    return {18'd0, a} * {18'd0, b};
`endif
  endfunction

  function automatic logic [47:0] m_to_x(input logic [35:0] m);
`ifdef DSP48A1_SIGNED_MULT_EN
    return {{12{m[35]}}, m};
`else
    return {12'd0, m};
`endif
  endfunction

  // Reference state of the default-parameter slice: what each registered stage holds.
  logic [7:0]  mo;
  logic [17:0] md, ma1, mb1;
  logic [35:0] mm;
  logic [47:0] mc, mp;
  logic        mcin, mco;

  always @(posedge clk) begin : ref_model
    logic [7:0]  op;
    logic [17:0] dv, a1v, b1v, pre, b1n;
    logic [35:0] mv;
    logic [47:0] cv, pv, xv, zv;
    logic        cinv;
    logic [48:0] sum;
    op   = dif.RSTOPMODE  ? 8'h00 : mo;
    dv   = dif.RSTD       ? 18'd0 : md;
    a1v  = dif.RSTA       ? 18'd0 : ma1;
    b1v  = dif.RSTB       ? 18'd0 : mb1;
    mv   = dif.RSTM       ? 36'd0 : mm;
    cv   = dif.RSTC       ? 48'd0 : mc;
    pv   = dif.RSTP       ? 48'd0 : mp;
    cinv = dif.RSTCARRYIN ? 1'b0  : mcin;
    pre  = op[6] ? dv - dif.B : dv + dif.B;
    b1n  = op[4] ? pre : dif.B;
    case (op[1:0])
      2'd0: xv = 48'd0;
      2'd1: xv = m_to_x(mv);
      2'd2: xv = pv;
      default: xv = {dv[11:0], a1v, b1v};
    endcase
    case (op[3:2])
      2'd0: zv = 48'd0;
      2'd1: zv = dif.PCIN;
      2'd2: zv = pv;
      default: zv = cv;
    endcase
    sum = op[7] ? ({1'b0, zv} - {1'b0, xv} - {48'd0, cinv})
                : ({1'b0, zv} + {1'b0, xv} + {48'd0, cinv});
    if (dif.RSTOPMODE) mo <= '0; else if (dif.CEOPMODE) mo <= dif.OPMODE;
    if (dif.RSTD) md <= '0; else if (dif.CED) md <= dif.D;
    if (dif.RSTB) mb1 <= '0; else if (dif.CEB) mb1 <= b1n;
    if (dif.RSTA) ma1 <= '0; else if (dif.CEA) ma1 <= dif.A;
    if (dif.RSTM) mm <= '0; else if (dif.CEM) mm <= mult(a1v, b1v);
    if (dif.RSTC) mc <= '0; else if (dif.CEC) mc <= dif.C;
    if (dif.RSTP) mp <= '0; else if (dif.CEP) mp <= sum[47:0];
    if (dif.RSTCARRYIN) begin
      mcin <= 1'b0;
      mco  <= 1'b0;
    end else if (dif.CECARRYIN) begin
      mcin <= op[5];
      mco  <= sum[48];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_p",         dif.P,         dif.RSTP ? 48'd0 : mp);
      checkOutput("model_pcout",     dif.PCOUT,     dif.RSTP ? 48'd0 : mp);
      checkOutput("model_m",         {12'd0, dif.M},     dif.RSTM ? 48'd0 : {12'd0, mm});
      checkOutput("model_bcout",     {30'd0, dif.BCOUT}, dif.RSTB ? 48'd0 : {30'd0, mb1});
      checkOutput("model_carryout",  {47'd0, dif.CARRYOUT},  dif.RSTCARRYIN ? 48'd0 : {47'd0, mco});
      checkOutput("model_carryoutf", {47'd0, dif.CARRYOUTF}, dif.RSTCARRYIN ? 48'd0 : {47'd0, mco});
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    model_on = 1'b0;

    set_controls(8'hFF, 8'hFF);
    applyStimulus(18'd5, 18'd7, 18'd3, 18'd4, 48'd9, 48'd1, 1'b1, 8'hFF);
    tick(1);
    #1;
    checkOutput("rst_p",        dif.P, 48'd0);
    checkOutput("rst_pcout",    dif.PCOUT, 48'd0);
    checkOutput("rst_m",        {12'd0, dif.M}, 48'd0);
    checkOutput("rst_bcout",    {30'd0, dif.BCOUT}, 48'd0);
    checkOutput("rst_carryout", {47'd0, dif.CARRYOUT}, 48'd0);
    checkOutput("rst_casc_p",   cif.P, 48'd0);
    set_controls(8'h00, 8'hFF);
    model_on = 1'b1;

    applyStimulus(18'd8, 18'd15, 18'd20, 18'd10, 48'd10, 48'd0, 1'b0, 8'h10);
    #1;
    checkOutput("casc_bcout", {30'd0, cif.BCOUT}, 48'd30);
    checkOutput("casc_m",     {12'd0, cif.M}, 48'd240);
    tick(1);
    #1;
    checkOutput("casc_p0", cif.P, 48'd0);

    applyStimulus(18'd8, 18'd15, 18'd20, 18'd10, 48'd10, 48'd0, 1'b0, 8'h1E);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      #1;
      checkOutput("casc_accum", cif.P, 48'(10 * i));
    end

    applyStimulus(18'd2, 18'd3, 18'd0, 18'd0, 48'd100, 48'd0, 1'b0, 8'hBD);
    tick(5);
    #1;
    checkOutput("sub_p",        dif.P, 48'd93);
    checkOutput("sub_m",        {12'd0, dif.M}, 48'd6);
    checkOutput("sub_carryout", {47'd0, dif.CARRYOUT}, 48'd0);

    applyStimulus(18'd0, 18'd1, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 8'h0F);
    tick(5);
    #1;
    checkOutput("wrap_p",         dif.P, 48'd0);
    checkOutput("wrap_pcout",     dif.PCOUT, 48'd0);
    checkOutput("wrap_carryout",  {47'd0, dif.CARRYOUT}, 48'd1);
    checkOutput("wrap_carryoutf", {47'd0, dif.CARRYOUTF}, 48'd1);

    applyStimulus(18'd3, 18'd4, 18'd0, 18'd0, 48'd50, 48'd0, 1'b0, 8'h0D);
    tick(5);
    #1;
    checkOutput("hold_pre_p", dif.P, 48'd62);
    set_controls(8'h00, 8'hDF);
    applyStimulus(18'd1, 18'd2, 18'd0, 18'd0, 48'd7, 48'd0, 1'b0, 8'h0D);
    tick(3);
    #1;
    checkOutput("hold_p", dif.P, 48'd62);
    set_controls(8'h20, 8'hDF);
    #1;
    checkOutput("async_rstp_p",     dif.P, 48'd0);
    checkOutput("async_rstp_pcout", dif.PCOUT, 48'd0);
    tick(1);
    set_controls(8'h00, 8'hFF);
    tick(3);
    #1;
    checkOutput("resume_p", dif.P, 48'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
